// File: rtl/mw_eeprom_ctrl.sv
// mw_eeprom_ctrl: single-command sequencer for a 93xx Microwire serial EEPROM (x16).
//
// Drives the serial pins for READ, WRITE, ERASE, EWEN, EWDS, ERAL and WRAL. Program
// operations finish with a ready/busy poll on DO.
//
// Optional build macro MW_TIMEOUT_EN: the ready poll gives up after POLL_MAX samples and
// reports rsp_err. Without it, the poll waits until DO goes high or rst is asserted.
//
// Ports:
//   clk, rst         system clock; asynchronous active-high reset
//   cmd_valid/ready  command handshake; cmd_ready is high only in IDLE
//   cmd_op           2-bit Microwire opcode (00 selects extended ops via cmd_addr top bits)
//   cmd_addr         word address / extended op select
//   cmd_wdata        write data for WRITE/WRAL
//   rsp_valid        one-cycle completion pulse
//   rsp_rdata        last READ data, held until the next READ completes
//   rsp_err          READ dummy-bit error or poll timeout, valid with rsp_valid
//   busy             ~cmd_ready
//   mw_cs/sk/di      EEPROM chip select, serial clock, serial data in
//   mw_do            EEPROM serial data out / ready status (asynchronous, synchronised here)
module mw_eeprom_ctrl #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned SK_DIV   = 4,
  parameter int unsigned POLL_MAX = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              mw_cs,
  output logic              mw_sk,
  output logic              mw_di,
  input  logic              mw_do
);

  localparam int unsigned HDR_W   = 3 + ADDR_W;
  localparam int unsigned BIT_MAX = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int unsigned CNT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
  localparam int unsigned DIV_W   = (SK_DIV > 1) ? $clog2(SK_DIV) : 1;
`ifdef MW_TIMEOUT_EN
  localparam int unsigned POLL_W  = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StRdata,
    StWdata,
    StPollGap,
    StPoll,
    StFin,
    StGap
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [1:0]          ext_q, ext_d;
  logic [HDR_W-1:0]    hdr_q, hdr_d;
  logic [DATA_W-1:0]   wsh_q, wsh_d;
  logic [DATA_W-1:0]   rsh_q, rsh_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic                cs_q, cs_d;
  logic                sk_q, sk_d;
  logic                di_q, di_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                half_q, half_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic                do_s1_q, do_s1_d;
  logic                do_s2_q, do_s2_d;
`ifdef MW_TIMEOUT_EN
  logic [POLL_W-1:0]   poll_q, poll_d;
`endif

  logic tick, slot_end, sk_rise;
  logic is_read, has_wdata, is_prog;
  logic hdr_last, data_last;

  // One slot = low half then high half of SK, each SK_DIV clocks long.
  assign tick     = (div_q == DIV_W'(SK_DIV - 1));
  assign slot_end = tick & half_q;
  assign sk_rise  = tick & ~half_q;

  assign is_read   = (op_q == 2'b10);
  assign has_wdata = (op_q == 2'b01) || ((op_q == 2'b00) && (ext_q == 2'b01));
  assign is_prog   = (op_q == 2'b01) || (op_q == 2'b11) ||
                     ((op_q == 2'b00) && ((ext_q == 2'b10) || (ext_q == 2'b01)));

  assign hdr_last  = (bit_q == CNT_W'(HDR_W - 1));
  assign data_last = (bit_q == CNT_W'(DATA_W - 1));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ext_d       = ext_q;
    hdr_d       = hdr_q;
    wsh_d       = wsh_q;
    rsh_d       = rsh_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    cs_d        = cs_q;
    sk_d        = sk_q;
    di_d        = di_q;
    bit_d       = bit_q;
    do_s1_d     = mw_do;
    do_s2_d     = do_s1_q;
`ifdef MW_TIMEOUT_EN
    poll_d      = poll_q;
`endif
    // Slot timer free-runs; states that need it parked override below.
    if (tick) begin
      div_d  = '0;
      half_d = ~half_q;
    end else begin
      div_d  = div_q + DIV_W'(1);
      half_d = half_q;
    end

    unique case (state_q)
      StIdle: begin
        div_d  = '0;
        half_d = 1'b0;
        if (cmd_valid) begin
          op_d    = cmd_op;
          ext_d   = cmd_addr[ADDR_W-1 -: 2];
          hdr_d   = {1'b1, cmd_op, cmd_addr};
          wsh_d   = cmd_wdata;
          err_d   = 1'b0;
          bit_d   = '0;
          state_d = StHdr;
        end
      end

      StHdr: begin
        if (!cs_q) begin
          // First cycle after accept: raise CS and present the start bit.
          cs_d   = 1'b1;
          sk_d   = 1'b0;
          di_d   = hdr_q[HDR_W-1];
          div_d  = '0;
          half_d = 1'b0;
        end else begin
          if (sk_rise) sk_d = 1'b1;
          if (slot_end) begin
            sk_d  = 1'b0;
            hdr_d = hdr_q << 1;
            if (hdr_last) begin
              bit_d = '0;
              if (is_read) begin
                // DO must show the dummy 0 after the last address bit.
                if (do_s2_q) err_d = 1'b1;
                di_d    = 1'b0;
                state_d = StRdata;
              end else if (has_wdata) begin
                di_d    = wsh_q[DATA_W-1];
                state_d = StWdata;
              end else if (is_prog) begin
                cs_d    = 1'b0;
                di_d    = 1'b0;
                state_d = StPollGap;
              end else begin
                cs_d    = 1'b0;
                di_d    = 1'b0;
                state_d = StFin;
              end
            end else begin
              bit_d = bit_q + CNT_W'(1);
              di_d  = hdr_q[HDR_W-2];
            end
          end
        end
      end

      StRdata: begin
        if (sk_rise) sk_d = 1'b1;
        if (slot_end) begin
          sk_d  = 1'b0;
          rsh_d = {rsh_q[DATA_W-2:0], do_s2_q};
          if (data_last) begin
            bit_d   = '0;
            cs_d    = 1'b0;
            di_d    = 1'b0;
            state_d = StFin;
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end
      end

      StWdata: begin
        if (sk_rise) sk_d = 1'b1;
        if (slot_end) begin
          sk_d  = 1'b0;
          wsh_d = wsh_q << 1;
          if (data_last) begin
            bit_d   = '0;
            cs_d    = 1'b0;
            di_d    = 1'b0;
            state_d = StPollGap;
          end else begin
            bit_d = bit_q + CNT_W'(1);
            di_d  = wsh_q[DATA_W-2];
          end
        end
      end

      // CS low for one slot time (tCS) starts the internal program cycle.
      StPollGap: begin
        if (slot_end) begin
          cs_d    = 1'b1;
          sk_d    = 1'b0;
          di_d    = 1'b0;
`ifdef MW_TIMEOUT_EN
          poll_d  = '0;
`endif
          state_d = StPoll;
        end
      end

      // DO reads 0 while busy, 1 when ready; SK stays low.
      StPoll: begin
        if (slot_end) begin
          if (do_s2_q) begin
            cs_d    = 1'b0;
            state_d = StFin;
          end
`ifdef MW_TIMEOUT_EN
          else if (poll_q == POLL_W'(POLL_MAX - 1)) begin
            err_d   = 1'b1;
            cs_d    = 1'b0;
            state_d = StFin;
          end else begin
            poll_d = poll_q + POLL_W'(1);
          end
`endif
        end
      end

      StFin: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        if (is_read) rdata_d = rsh_q;
        div_d   = '0;
        half_d  = 1'b0;
        state_d = StGap;
      end

      StGap: begin
        if (slot_end) state_d = StIdle;
      end

      default: begin
        cs_d    = 1'b0;
        sk_d    = 1'b0;
        di_d    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= '0;
      ext_q       <= '0;
      hdr_q       <= '0;
      wsh_q       <= '0;
      rsh_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      cs_q        <= 1'b0;
      sk_q        <= 1'b0;
      di_q        <= 1'b0;
      div_q       <= '0;
      half_q      <= 1'b0;
      bit_q       <= '0;
      do_s1_q     <= 1'b0;
      do_s2_q     <= 1'b0;
`ifdef MW_TIMEOUT_EN
      poll_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ext_q       <= ext_d;
      hdr_q       <= hdr_d;
      wsh_q       <= wsh_d;
      rsh_q       <= rsh_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      cs_q        <= cs_d;
      sk_q        <= sk_d;
      di_q        <= di_d;
      div_q       <= div_d;
      half_q      <= half_d;
      bit_q       <= bit_d;
      do_s1_q     <= do_s1_d;
      do_s2_q     <= do_s2_d;
`ifdef MW_TIMEOUT_EN
      poll_q      <= poll_d;
`endif
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = ~cmd_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rdata_q;
  assign mw_cs     = cs_q;
  assign mw_sk     = sk_q;
  assign mw_di     = di_q;

endmodule

// File: tb/tb_mw_eeprom_ctrl.sv
// Directed bench for mw_eeprom_ctrl with a behavioural 93C46 (x16) pin model.
module tb_mw_eeprom_ctrl;

`ifdef MW_TIMEOUT_EN
  localparam int unsigned TbPollMax = 8;
`else
  localparam int unsigned TbPollMax = 4096;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [5:0]  cmd_addr = 6'h00;
  logic [15:0] cmd_wdata = 16'h0000;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        mw_cs, mw_sk, mw_di;
  logic        do_r = 1'b1;

  int tests = 0;
  int fails = 0;

  mw_eeprom_ctrl #(
    .ADDR_W  (6),
    .DATA_W  (16),
    .SK_DIV  (4),
    .POLL_MAX(TbPollMax)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .mw_cs    (mw_cs),
    .mw_sk    (mw_sk),
    .mw_di    (mw_di),
    .mw_do    (do_r)
  );

  always #5 clk = ~clk;

  // EEPROM pin model, evaluated on the falling clock edge.
  logic [8:0]  m_hdr;
  logic [15:0] m_dat;
  logic [15:0] m_word = 16'h0000;
  int          m_nbits = 0;
  int          m_pcnt = 0;
  int          m_busy = 0;      // clocks after poll CS rise before ready; 0 = never
  logic        m_stuck1 = 1'b0;
  logic        m_poll = 1'b0;
  logic        m_pend = 1'b0;
  logic        m_cs_prev = 1'b0;
  logic        m_sk_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      m_nbits = 0; m_poll = 1'b0; m_pend = 1'b0; do_r = 1'b1;
      m_cs_prev = 1'b0; m_sk_prev = 1'b0;
    end else begin
      if (mw_cs && !m_cs_prev) begin
        if (m_pend) begin
          m_poll = 1'b1; m_pcnt = 0; do_r = 1'b0;
        end else begin
          m_nbits = 0; m_hdr = '0; m_dat = '0;
        end
        m_pend = 1'b0;
      end else if (m_poll && mw_cs) begin
        m_pcnt++;
        if (m_busy != 0 && m_pcnt == m_busy) do_r = 1'b1;
      end
      if (!mw_cs && m_cs_prev) begin
        if (m_poll) m_poll = 1'b0;
        else if ((m_hdr[7:6] == 2'b01 && m_nbits == 25) ||
                 (m_hdr[7:6] == 2'b11 && m_nbits == 9) ||
                 (m_hdr[7:4] == 4'b0010 && m_nbits == 9) ||
                 (m_hdr[7:4] == 4'b0001 && m_nbits == 25)) m_pend = 1'b1;
        do_r = 1'b1;
      end
      if (mw_cs && mw_sk && !m_sk_prev && !m_poll) begin
        if (m_nbits < 9) m_hdr = {m_hdr[7:0], mw_di};
        else m_dat = {m_dat[14:0], mw_di};
        m_nbits++;
        if (m_hdr[8] && m_hdr[7:6] == 2'b10 && m_nbits >= 9 && m_nbits <= 25) begin
          if (m_nbits == 9) do_r = 1'b0;
          else do_r = m_word[25 - m_nbits];
        end
      end
      if (m_stuck1) do_r = 1'b1;
      m_cs_prev = mw_cs;
      m_sk_prev = mw_sk;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command and run until rsp_valid or the cycle budget expires. Cycle n is
  // sampled 1 time unit after the n-th rising edge following the accept edge.
  task automatic run_cmd(input logic [1:0] op, input logic [5:0] addr, input logic [15:0] wd,
                         input int max_cyc, output int n_valid, output int n_hi,
                         output int n_lo, output int n_hi2);
    int n;
    logic prev_cs;
    cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    n = 0; n_valid = 0; n_hi = 0; n_lo = 0; n_hi2 = 0; prev_cs = mw_cs;
    while (n < max_cyc && n_valid == 0) begin
      @(posedge clk); #1; n++;
      if (mw_cs && !prev_cs) begin
        if (n_hi == 0) n_hi = n;
        else if (n_hi2 == 0) n_hi2 = n;
      end
      if (!mw_cs && prev_cs && n_lo == 0) n_lo = n;
      prev_cs = mw_cs;
      if (rsp_valid) n_valid = n;
    end
  endtask

  task automatic wait_ready(input int max_cyc, output int k);
    k = 0;
    while (k < max_cyc && !cmd_ready) begin
      @(posedge clk); #1; k++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, nh, nl, nh2, k, n, nacc, bad;
    logic prev_ready;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs", mw_cs, 1'b0);
    check("rst_sk", mw_sk, 1'b0);
    check("rst_di", mw_di, 1'b0);
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_err", rsp_err, 1'b0);
    check("rst_rdata", rsp_rdata, 16'h0000);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // READ 0x15 returning 0xA5C3
    m_word = 16'hA5C3;
    run_cmd(2'b10, 6'h15, 16'h0000, 400, nv, nh, nl, nh2);
    check("rd_cs_rise", nh, 1);
    check("rd_cs_fall", nl, 201);
    check("rd_valid_clk", nv, 202);
    check("rd_header", m_hdr, 9'h195);
    check("rd_rdata", rsp_rdata, 16'hA5C3);
    check("rd_err", rsp_err, 1'b0);
    check("rd_busy", busy, 1'b1);
    @(posedge clk); #1;
    check("rd_pulse", rsp_valid, 1'b0);
    wait_ready(50, k);
    check("rd_gap", k + 1, 8);

    // READ with DO stuck high
    m_stuck1 = 1'b1;
    run_cmd(2'b10, 6'h2A, 16'h0000, 400, nv, nh, nl, nh2);
    check("stk_cs_fall", nl, 201);
    check("stk_valid_clk", nv, 202);
    check("stk_rdata", rsp_rdata, 16'hFFFF);
    check("stk_err", rsp_err, 1'b1);
    m_stuck1 = 1'b0;
    wait_ready(50, k);

    // EWEN: header only
    run_cmd(2'b00, 6'h30, 16'h0000, 400, nv, nh, nl, nh2);
    check("ewen_header", m_hdr, 9'h130);
    check("ewen_valid_clk", nv, 74);
    check("ewen_err", rsp_err, 1'b0);
    check("ewen_rdata_held", rsp_rdata, 16'hFFFF);
    wait_ready(50, k);

    // WRITE 0x02 <- 0x1234, ready on the 11th poll sample
    m_busy = 82;
    run_cmd(2'b01, 6'h02, 16'h1234, 600, nv, nh, nl, nh2);
    check("wr_header", m_hdr, 9'h142);
    check("wr_data", m_dat, 16'h1234);
    check("wr_cs_fall", nl, 201);
    check("wr_poll_cs_rise", nh2, 209);
    check("wr_valid_clk", nv, 298);
    check("wr_err", rsp_err, 1'b0);
    wait_ready(50, k);

    // Second command held on cmd_valid while a READ is running
    m_word = 16'h5A3C;
    cmd_op = 2'b10; cmd_addr = 6'h15; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_op = 2'b00; cmd_addr = 6'h00;
    n = 0; nv = 0; nacc = 0; prev_ready = cmd_ready;
    while (n < 500 && nacc == 0) begin
      @(posedge clk); #1; n++;
      if (rsp_valid && nv == 0) begin
        nv = n;
        check("hold_rd_header", m_hdr, 9'h195);
        check("hold_rd_rdata", rsp_rdata, 16'h5A3C);
      end
      if (prev_ready && !cmd_ready) begin
        nacc = n;
        cmd_valid = 1'b0;
      end
      prev_ready = cmd_ready;
    end
    cmd_valid = 1'b0;
    check("hold_rd_valid_clk", nv, 202);
    check("hold_accept_clk", nacc, 211);
    @(posedge clk); #1; n++;
    check("hold_cs_rise", mw_cs, 1'b1);
    nv = 0;
    while (n < 600 && nv == 0) begin
      @(posedge clk); #1; n++;
      if (rsp_valid) nv = n;
    end
    check("hold_ewds_valid_clk", nv, 285);
    check("hold_ewds_header", m_hdr, 9'h100);
    check("hold_ewds_err", rsp_err, 1'b0);
    wait_ready(50, k);

    // Reset in the middle of the data phase (15th data slot, SK high, DI=1)
    cmd_op = 2'b01; cmd_addr = 6'h02; cmd_wdata = 16'h1236; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (190) @(posedge clk);
    #1;
    check("mid_cs_before", mw_cs, 1'b1);
    check("mid_sk_before", mw_sk, 1'b1);
    check("mid_di_before", mw_di, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_cs_rst", mw_cs, 1'b0);
    check("mid_sk_rst", mw_sk, 1'b0);
    check("mid_di_rst", mw_di, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || mw_cs) bad++;
    end
    check("mid_no_rsp", bad, 0);
    check("mid_ready", cmd_ready, 1'b1);

    // ERASE with DO never ready
    m_busy = 0;
`ifdef MW_TIMEOUT_EN
    run_cmd(2'b11, 6'h05, 16'h0000, 400, nv, nh, nl, nh2);
    check("to_header", m_hdr, 9'h1C5);
    check("to_valid_clk", nv, 146);
    check("to_err", rsp_err, 1'b1);
    wait_ready(50, k);
    check("to_ready", cmd_ready, 1'b1);
`else
    run_cmd(2'b11, 6'h05, 16'h0000, 10000, nv, nh, nl, nh2);
    check("nto_header", m_hdr, 9'h1C5);
    check("nto_no_valid", nv, 0);
    check("nto_busy", busy, 1'b1);
    check("nto_cs", mw_cs, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("nto_ready", cmd_ready, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
